// File: rtl/pattern_scan_ctrl.sv
// Bit-serial pattern scanner: accepts a byte, shifts it MSB first through a
// pattern history and counts matches. Optional irq logic under PATTERN_SCAN_IRQ_EN.
module pattern_scan_ctrl #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10001,
    parameter int               CNT_W   = 8,
    parameter int               THRESH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    input  logic             irq_clr,
    output logic             irq
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [7:0]         data_q;
    logic [2:0]         bit_idx;
    logic [PAT_W-1:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [CNT_W-1:0]   cnt;
    logic               pulse_q;

    logic               take;
    logic               shift_bit;
    logic [PAT_W-1:0]   hist_next;
    logic               hit;
    logic               cnt_sat;

    assign in_ready  = (state == IDLE) && !clear && rst_n;
    assign busy      = (state == SHIFT) && rst_n;
    assign take      = in_valid && in_ready;
    assign shift_bit = data_q[bit_idx];
    assign hist_next = PAT_W'({hist, shift_bit});
    // fill counts bits shifted before this one, so the window is full once it reaches PAT_W-1
    assign hit       = (state == SHIFT) && (hist_next == PATTERN) && (fill >= FILL_ARM);
    assign cnt_sat   = &cnt;

    assign match_pulse = pulse_q;
    assign match_count = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            bit_idx <= '0;
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            bit_idx <= '0;
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= hit;
            if (hit && !cnt_sat) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        data_q  <= in_data;
                        bit_idx <= 3'd7;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist    <= hist_next;
                    bit_idx <= bit_idx - 3'd1;
                    if (fill != FILL_FULL) begin
                        fill <= fill + FILL_W'(1);
                    end
                    if (bit_idx == 3'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PATTERN_SCAN_IRQ_EN
    logic irq_q;
    logic irq_set;

    // clear suppresses the count update, so it also suppresses the irq set
    assign irq_set = hit && !clear && !cnt_sat && ((32'(cnt) + 32'd1) == 32'(THRESH));
    assign irq     = irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end
`else
    localparam int unused_thresh = THRESH;
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized and directed bench for pattern_scan_ctrl against a queue-based bit-stream model.
`timescale 1ns/1ps
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       irq_clr = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready, busy, match_pulse, irq;
    logic [7:0] match_count;
    logic       s_in_ready, s_busy, s_pulse, s_irq;
    logic [1:0] s_count;

    int checks = 0;
    int errors = 0;
    int obs_pulses = 0;
    int obs_s_pulses = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
        .match_count(match_count), .irq_clr(irq_clr), .irq(irq)
    );

    pattern_scan_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .busy(s_busy), .match_pulse(s_pulse),
        .match_count(s_count), .irq_clr(irq_clr), .irq(s_irq)
    );

    // Reference: bytes become a queue of pending bits; the last five bits since clear form the window.
    bit   pend[$];
    bit   win[$];
    int   m_cnt = 0;
    int   m_cnt_s = 0;
    logic m_pulse = 1'b0;
    logic m_irq = 1'b0;
    logic [4:0] pat = 5'b10001;

    always @(posedge clk) begin
        logic hit;
        int   prev;
        hit  = 1'b0;
        prev = m_cnt;
        if (!rst_n) begin
            pend.delete(); win.delete();
            m_cnt = 0; m_cnt_s = 0; m_pulse = 1'b0; m_irq = 1'b0;
        end else begin
            if (clear) begin
                pend.delete(); win.delete();
                m_cnt = 0; m_cnt_s = 0;
            end else if (pend.size() != 0) begin
                win.push_back(pend.pop_front());
                if (win.size() > 5) win.delete(0);
                if (win.size() == 5) begin
                    hit = 1'b1;
                    for (int k = 0; k < 5; k++) if (win[k] != pat[4-k]) hit = 1'b0;
                end
                if (hit) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt_s < 3) m_cnt_s++;
                end
            end else if (in_valid) begin
                for (int k = 7; k >= 0; k--) pend.push_back(in_data[k]);
            end
            m_pulse = hit;
`ifdef PATTERN_SCAN_IRQ_EN
            if (hit && prev == 3) m_irq = 1'b1;
            else if (irq_clr) m_irq = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (match_pulse === 1'b1) obs_pulses++;
        if (s_pulse === 1'b1) obs_s_pulses++;
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic clear_scan();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h88;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (match_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", match_pulse); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", match_count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        in_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_midbyte();
        int p0;
        clear_scan();
        send(8'h88);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p0 = obs_pulses;
        repeat (10) @(negedge clk);
        checks++; if (obs_pulses != p0) begin errors++; $display("FAIL reset_mid_pulses: got %0d want 0", obs_pulses - p0); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_mid_count: got %0d want 0", match_count); end
    endtask

    task automatic test_basic();
        logic exp;
        clear_scan();
        send(8'h88);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp = (i == 5);
            checks++; if (match_pulse !== exp) begin errors++; $display("FAIL basic_pulse[%0d]: got %b want %b", i, match_pulse, exp); end
            exp = (i < 8);
            checks++; if (busy !== exp) begin errors++; $display("FAIL basic_busy[%0d]: got %b want %b", i, busy, exp); end
        end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", match_count); end
    endtask

    task automatic test_cross_byte();
        int p0;
        logic exp;
        clear_scan();
        p0 = obs_pulses;
        send(8'h89);
        send(8'h18);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp = (i == 4);
            checks++; if (match_pulse !== exp) begin errors++; $display("FAIL cross_pulse[%0d]: got %b want %b", i, match_pulse, exp); end
        end
        checks++; if (obs_pulses - p0 != 2) begin errors++; $display("FAIL cross_pulses: got %0d want 2", obs_pulses - p0); end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL cross_count: got %0d want 2", match_count); end
    endtask

    task automatic test_back_to_back();
        logic exp;
        clear_scan();
        send(8'h88);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp = (i == 8);
            checks++; if (in_ready !== exp) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, in_ready, exp); end
            exp = (i == 5);
            checks++; if (match_pulse !== exp) begin errors++; $display("FAIL b2b_pulse1[%0d]: got %b want %b", i, match_pulse, exp); end
        end
        send(8'h80);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp = (i == 1);
            checks++; if (match_pulse !== exp) begin errors++; $display("FAIL b2b_pulse2[%0d]: got %b want %b", i, match_pulse, exp); end
        end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", match_count); end
    endtask

    task automatic test_saturation();
        int p0, ps0;
        clear_scan();
        p0 = obs_pulses; ps0 = obs_s_pulses;
        repeat (4) send(8'h88);
        repeat (10) @(negedge clk);
        checks++; if (s_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", s_count); end
        checks++; if (obs_s_pulses - ps0 != 7) begin errors++; $display("FAIL sat_pulses: got %0d want 7", obs_s_pulses - ps0); end
        checks++; if (match_count !== 8'd7) begin errors++; $display("FAIL sat_wide_count: got %0d want 7", match_count); end
        checks++; if (obs_pulses - p0 != 7) begin errors++; $display("FAIL sat_wide_pulses: got %0d want 7", obs_pulses - p0); end
    endtask

    task automatic test_clear_midbyte();
        int p0;
        clear_scan();
        send(8'h88);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_during: got %b want 0", in_ready); end
        @(negedge clk);
        clear = 1'b0;
        p0 = obs_pulses;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_after: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (obs_pulses != p0) begin errors++; $display("FAIL clr_pulses: got %0d want 0", obs_pulses - p0); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", match_count); end
    endtask

    task automatic test_irq();
`ifdef PATTERN_SCAN_IRQ_EN
        clear_scan();
        irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
        send(8'h88); send(8'h88); send(8'h80);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq); end
        @(negedge clk);
        checks++; if (match_count !== 8'd4) begin errors++; $display("FAIL irq_count4: got %0d want 4", match_count); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
        irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
        send(8'h88);
        repeat (10) @(negedge clk);
        checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL irq_count5: got %0d want 5", match_count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fifth: got %b want 0", irq); end
        clear_scan();
        send(8'h88); send(8'h88); send(8'h80);
        irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
        clear_scan();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_kept_by_clear: got %b want 1", irq); end
        irq_clr = 1'b1; @(negedge clk); irq_clr = 1'b0;
`else
        clear_scan();
        irq_clr = 1'b0;
        repeat (3) send(8'h88);
        repeat (10) @(negedge clk);
        checks++; if (match_count !== 8'd5) begin errors++; $display("FAIL noirq_count: got %0d want 5", match_count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL noirq_irq: got %b want 0", irq); end
`endif
    endtask

    task automatic test_random();
        logic exp_ready, exp_busy;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp_ready = (pend.size() == 0) && !clear && rst_n;
            exp_busy  = (pend.size() != 0) && rst_n;
            checks++; if (match_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse@%0d: got %b want %b", c, match_pulse, m_pulse); end
            checks++; if (match_count !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, match_count, m_cnt); end
            checks++; if (s_count !== 2'(m_cnt_s)) begin errors++; $display("FAIL rnd_sat_count@%0d: got %0d want %0d", c, s_count, m_cnt_s); end
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, in_ready, exp_ready); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, exp_busy); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq@%0d: got %b want %b", c, irq, m_irq); end
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = ($urandom_range(0, 1) == 0) ? 8'h88 : 8'($urandom);
            clear    = ($urandom_range(0, 59) == 0);
            irq_clr  = ($urandom_range(0, 24) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
        end
        in_valid = 1'b0; clear = 1'b0; irq_clr = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_byte();
        test_back_to_back();
        test_saturation();
        test_clear_midbyte();
        test_reset_midbyte();
        test_irq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern length in bits.
REQ-002 SHALL have parameter PATTERN, default 5'b10001, the pattern to detect, oldest bit in the MSB.
REQ-003 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-004 SHALL have parameter THRESH, default 4, match count that raises irq.
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port clear, input, 1 bit: synchronous scan clear.
REQ-008 SHALL have port in_valid, input, 1 bit: byte offered.
REQ-009 SHALL have port in_data, input, 8 bits: byte, serialised MSB first.
REQ-010 SHALL have port in_ready, output, 1 bit: byte accepted when in_valid && in_ready.
REQ-011 SHALL have port busy, output, 1 bit: high while a byte is being serialised.
REQ-012 SHALL have port match_pulse, output, 1 bit: one-cycle pulse per detected match.
REQ-013 SHALL have port match_count, output, CNT_W bits: total matches, saturating.
REQ-014 SHALL have port irq_clr, input, 1 bit: clears irq.
REQ-015 SHALL have port irq, output, 1 bit: sticky threshold flag.

Function
REQ-016 SHALL use a two-state FSM, IDLE and SHIFT; busy SHALL be high exactly when the state is SHIFT.
REQ-017 SHALL drive in_ready = (state==IDLE) && !clear && rst_n, as a combinational output.
REQ-018 SHALL, on a transfer at edge T, latch in_data and enter SHIFT, with a bit index starting at 7.
REQ-019 SHALL, in SHIFT, shift one bit per cycle, MSB first, into a PAT_W-bit history register, newest bit in the LSB.
REQ-020 SHALL shift the 8th bit at edge T+8 and return to IDLE there, so in_ready is high again after T+8 and peak throughput is one byte per 9 cycles.
REQ-021 SHALL keep the history and fill count across bytes, so patterns spanning a byte boundary are detected.
REQ-022 SHALL detect a match when the updated history equals PATTERN and at least PAT_W bits have been shifted since the last reset or clear.
REQ-023 SHALL detect overlapping matches.
REQ-024 SHALL assert match_pulse for exactly the one cycle following the edge that shifted the completing bit.
REQ-025 SHALL increment match_count on that same edge.
REQ-026 SHALL saturate match_count at 2^CNT_W-1, with no wrap; match_pulse SHALL still fire when saturated.
REQ-027 SHALL, on clear, force IDLE, abort any in-flight byte, discard its remaining bits, and zero the history, fill count, match_count and match_pulse.
REQ-028 SHALL let clear win over a simultaneous match or a simultaneous in_valid; no transfer occurs in that cycle.
REQ-029 SHALL ignore in_valid while the state is SHIFT; in_data is sampled only at transfer.

Reset
REQ-030 SHALL, while rst_n is low at a rising edge, set state IDLE and zero the history, bit index, fill count, match_count, match_pulse and irq.
REQ-031 SHALL hold in_ready and busy low while rst_n is low.
REQ-032 SHALL, when reset is asserted mid-byte, abandon the byte with no match and no count update.

Configuration
REQ-033 SHALL compile the irq logic only when macro PATTERN_SCAN_IRQ_EN is defined.
REQ-034 SHALL, with PATTERN_SCAN_IRQ_EN defined, set irq on the edge where match_count becomes equal to THRESH, hold it until irq_clr, and let set win over a simultaneous irq_clr.
REQ-035 SHALL, with PATTERN_SCAN_IRQ_EN defined, never clear irq through clear.
REQ-036 SHALL, without PATTERN_SCAN_IRQ_EN, tie irq to 0, ignore irq_clr and leave THRESH unused; all other behaviour is identical.

Verification
REQ-037 SHALL cover a basic match: byte 8'h88 (10001000) -> exactly one match_pulse, in the cycle after the 5th shift edge; match_count=1.
REQ-038 SHALL cover a cross-byte match: bytes 8'h89 then 8'h18 -> two pulses, the second completing on the 4th bit of byte 2; match_count=2.
REQ-039 SHALL cover overlap: bytes 8'h88 then 8'h80 -> two pulses, the second on the 1st bit of byte 2; in_ready low during each SHIFT, high after edge T+8.
REQ-040 SHALL cover saturation: CNT_W=2 and seven matches -> match_count stays 3 and match_pulse still fires on every match.
REQ-041 SHALL cover clear mid-byte: clear asserted at bit 3 of 8'h88 -> no pulse, match_count=0, state IDLE and in_ready high the next cycle.
REQ-042 SHALL cover irq with PATTERN_SCAN_IRQ_EN defined and THRESH=4: 4 matches -> irq rises on the 4th count edge; irq_clr drops it; a 5th match does not set it; irq_clr coinciding with the count reaching 4 -> irq=1.
